// File: rtl/mem_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_seq_ctrl_if
//   Bundles the pipeline-side request/response signals and the byte-wide
//   memory bus of mem_seq_ctrl.
//   slave  : the sequencer (requests in, stall/done/results and memory
//            strobes out, memory read data in)
//   master : the pipeline stage plus memory model driving the sequencer
// Parameters: I lanes, L bits per lane / memory word, A byte-address bits.
// ---------------------------------------------------------------------------
interface mem_seq_ctrl_if #(
    parameter int I = 20,
    parameter int L = 8,
    parameter int A = 32
);
    // pipeline side
    logic             req_i;
    logic             op_vector_i;
    logic             we_i;
    logic [A-1:0]     addr_i;
    logic [I*L-1:0]   wdata_v_i;
    logic [L-1:0]     wdata_s_i;
    logic             stall_o;
    logic             done_o;
    logic [I*L-1:0]   rdata_v_o;
    logic [L-1:0]     rdata_s_o;
    // memory side
    logic             mem_en_o;
    logic             mem_we_o;
    logic [A-1:0]     mem_addr_o;
    logic [L-1:0]     mem_wdata_o;
    logic [L-1:0]     mem_rdata_i;

    modport slave (
        input  req_i, op_vector_i, we_i, addr_i, wdata_v_i, wdata_s_i, mem_rdata_i,
        output stall_o, done_o, rdata_v_o, rdata_s_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, op_vector_i, we_i, addr_i, wdata_v_i, wdata_s_i, mem_rdata_i,
        input  stall_o, done_o, rdata_v_o, rdata_s_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mem_seq_ctrl
//   Sequences a scalar (1 beat) or vector (I beats) load/store from the MEM
//   pipeline stage onto a byte-wide synchronous memory, stalling the
//   pipeline until the access completes.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_seq_ctrl_if.slave
//          req_i/op_vector_i/we_i/addr_i/wdata_v_i/wdata_s_i  request
//          stall_o/done_o/rdata_v_o/rdata_s_o                  response
//          mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o            memory strobe
//          mem_rdata_i                                         read data, 1 cycle
//                                                              after read strobe
// ---------------------------------------------------------------------------
module mem_seq_ctrl #(
    parameter int I = 20,
    parameter int L = 8,
    parameter int A = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_seq_ctrl_if.slave  bus
);
    localparam int CW = (I > 1) ? $clog2(I) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            vec_q, we_q;
    logic [A-1:0]    base_q;
    logic [I*L-1:0]  wdata_v_q;
    logic [L-1:0]    wdata_s_q;
    // read-return tracking: one entry, because data arrives one cycle later
    logic            rd_pend_q, rd_vec_q;
    logic [CW-1:0]   rd_idx_q;
    logic [L-1:0]    rdata_s_q;

    logic            accept, last_beat;
    logic [L-1:0]    wlane [I];

    logic            stall, done, mem_en, mem_we;
    logic [A-1:0]    mem_addr;
    logic [L-1:0]    mem_wdata;

    assign accept    = (state_q == S_IDLE) && bus.req_i;
    assign last_beat = !vec_q || (cnt_q == CW'(I - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.req_i) state_d = S_ACCESS;
            S_ACCESS: if (last_beat) state_d = we_q ? S_DONE : S_DRAIN;
            S_DRAIN:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Address/data are forced to zero outside ACCESS so the bus is never X
    // and reads as zero while reset is held.
    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE:   stall = bus.req_i;
            S_ACCESS: begin
                stall     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_q + A'(cnt_q);   // wraps mod 2^A
                mem_wdata = vec_q ? wlane[cnt_q] : wdata_s_q;
            end
            S_DRAIN:  stall = 1'b1;
            S_DONE:   done  = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    assign bus.stall_o     = stall;
    assign bus.done_o      = done;
    assign bus.mem_en_o    = mem_en;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.rdata_s_o   = rdata_s_q;

    // ---------------- operand latch, beat counter, read tracking ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            vec_q     <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
            wdata_v_q <= '0;
            wdata_s_q <= '0;
            rd_pend_q <= 1'b0;
            rd_vec_q  <= 1'b0;
            rd_idx_q  <= '0;
            rdata_s_q <= '0;
        end else begin
            if (accept) begin
                vec_q     <= bus.op_vector_i;
                we_q      <= bus.we_i;
                base_q    <= bus.addr_i;
                wdata_v_q <= bus.wdata_v_i;
                wdata_s_q <= bus.wdata_s_i;
                cnt_q     <= '0;
            end else if (state_q == S_ACCESS && !last_beat) begin
                cnt_q <= cnt_q + CW'(1);
            end
            // remember which lane the current read beat targets; its data
            // is captured on the following edge
            rd_pend_q <= (state_q == S_ACCESS) && !we_q;
            rd_vec_q  <= vec_q;
            rd_idx_q  <= cnt_q;
            if (rd_pend_q && !rd_vec_q) rdata_s_q <= bus.mem_rdata_i;
        end
    end

    // ---------------- per-lane write mux source and read result ----------------
    genvar gi;
    generate
        for (gi = 0; gi < I; gi++) begin : g_lane
            logic [L-1:0] lane_q;

            assign wlane[gi] = wdata_v_q[gi*L +: L];

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    lane_q <= '0;
                else if (rd_pend_q && rd_vec_q && rd_idx_q == CW'(gi))
                    lane_q <= bus.mem_rdata_i;
            end

            assign bus.rdata_v_o[gi*L +: L] = lane_q;
        end
    endgenerate
endmodule

// File: tb/tb_mem_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_seq_ctrl
//   Self-checking bench for mem_seq_ctrl. Expected memory strobes and read
//   results are queued when a request is driven and popped as the DUT
//   produces them. A byte memory model answers read strobes one cycle later.
// ---------------------------------------------------------------------------
module tb_mem_seq_ctrl;
    localparam int I = 20;
    localparam int L = 8;
    localparam int A = 32;

    typedef struct packed {
        logic         we;
        logic [A-1:0] addr;
        logic [L-1:0] data;
    } strobe_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_seq_ctrl_if #(.I(I), .L(L), .A(A)) bus();

    mem_seq_ctrl #(.I(I), .L(L), .A(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    strobe_t         exp_q [$];
    logic [I*L+L-1:0] res_q [$];
    logic [L-1:0]    mem [logic [A-1:0]];
    logic [I*L-1:0]  model_rv;
    logic [L-1:0]    model_rs;

    int n_vec = 0;
    int n_err = 0;
    int n_strobe;
    int n_done;
    bit rd_pend;
    logic [A-1:0] rd_addr;

    function automatic logic [L-1:0] mem_rd(input logic [A-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    function automatic logic [I*L-1:0] rand_vec();
        logic [I*L-1:0] v;
        for (int k = 0; k < I; k++) v[k*L +: L] = L'($urandom);
        return v;
    endfunction

    // Advance to the next falling edge, act as the memory and check the strobe.
    task automatic tick();
        strobe_t e;
        @(negedge clk);
        bus.mem_rdata_i = rd_pend ? mem_rd(rd_addr) : 8'hEE;
        rd_pend = 1'b0;
        if (bus.mem_en_o === 1'b1) begin
            n_vec++;
            n_strobe++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL strobe_unexpected: got we=%0b addr=%h data=%h, required none",
                         bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_we_o !== e.we || bus.mem_addr_o !== e.addr ||
                    (e.we && bus.mem_wdata_o !== e.data)) begin
                    n_err++;
                    $display("FAIL strobe: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                             bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, e.we, e.addr, e.data);
                end
            end
            if (bus.mem_we_o === 1'b1) mem[bus.mem_addr_o] = bus.mem_wdata_o;
            else begin rd_pend = 1'b1; rd_addr = bus.mem_addr_o; end
        end else if (bus.mem_we_o !== 1'b0) begin
            n_vec++; n_err++;
            $display("FAIL we_without_en: got mem_we_o=%0b, required 0", bus.mem_we_o);
        end
        if (bus.done_o === 1'b1) n_done++;
    endtask

    // Drive one request (at a falling edge) and follow it to completion.
    // Cycle 0 is the request cycle; done_o is expected at cycle 'lat'.
    task automatic run_op(input bit vec, input bit we, input logic [A-1:0] addr,
                          input logic [I*L-1:0] wv, input logic [L-1:0] ws,
                          input bit hold, input int busy_at, input string name);
        int lat, nb, c;
        bit seen;
        strobe_t s;
        logic [I*L+L-1:0] r;
        lat = vec ? (we ? I + 1 : I + 2) : (we ? 2 : 3);
        nb  = vec ? I : 1;
        n_strobe = 0; n_done = 0; seen = 1'b0; c = 0;
        bus.req_i = 1'b1; bus.op_vector_i = vec; bus.we_i = we;
        bus.addr_i = addr; bus.wdata_v_i = wv; bus.wdata_s_i = ws;
        for (int k = 0; k < nb; k++) begin
            s.we = we; s.addr = addr + A'(k);
            s.data = vec ? wv[k*L +: L] : ws;
            exp_q.push_back(s);
            if (!we) begin
                if (vec) model_rv[k*L +: L] = mem_rd(addr + A'(k));
                else     model_rs = mem_rd(addr);
            end
        end
        res_q.push_back({model_rv, model_rs});
        #1;
        n_vec++;
        if (bus.stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s_stall_req: got %0b, required 1", name, bus.stall_o);
        end
        while (!seen && c < lat + 3) begin
            tick();
            c++;
            if (bus.done_o === 1'b1) seen = 1'b1;
            else if (bus.stall_o !== 1'b1) begin
                n_vec++; n_err++;
                $display("FAIL %s_stall_busy: cycle %0d got %0b, required 1", name, c, bus.stall_o);
            end
            if (c == 1 && !hold) begin
                bus.req_i = 1'b0; bus.addr_i = $urandom; bus.we_i = ~we;
                bus.op_vector_i = ~vec; bus.wdata_v_i = rand_vec(); bus.wdata_s_i = L'($urandom);
            end
            if (busy_at > 0 && c == busy_at)     begin bus.req_i = 1'b1; bus.addr_i = 32'hDEAD0000; end
            if (busy_at > 0 && c == busy_at + 1) bus.req_i = 1'b0;
        end
        n_vec++;
        if (!seen || c != lat) begin
            n_err++;
            $display("FAIL %s_latency: got done at cycle %0d (seen=%0b), required %0d", name, c, seen, lat);
        end
        n_vec++;
        if (bus.stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s_stall_done: got %0b, required 0", name, bus.stall_o);
        end
        r = res_q.pop_front();
        n_vec++;
        if ({bus.rdata_v_o, bus.rdata_s_o} !== r) begin
            n_err++;
            $display("FAIL %s_rdata: got v=%h s=%h, required v=%h s=%h", name,
                     bus.rdata_v_o, bus.rdata_s_o, r[I*L+L-1:L], r[L-1:0]);
        end
        n_vec++;
        if (exp_q.size() != 0 || n_strobe != nb) begin
            n_err++;
            $display("FAIL %s_strobes: got %0d issued, %0d missing, required %0d", name,
                     n_strobe, exp_q.size(), nb);
            exp_q.delete();
        end
        $display("op %s: vec=%0b we=%0b addr=%h strobes=%0d done_cycle=%0d", name, vec, we, addr, n_strobe, c);
        tick();
        n_vec++;
        if (bus.done_o !== 1'b0 || bus.mem_en_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after_done: got done=%0b en=%0b, required 0 0", name, bus.done_o, bus.mem_en_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = 1'b0; bus.op_vector_i = 1'b0; bus.we_i = 1'b1;
        bus.addr_i = 32'h10000; bus.wdata_v_i = '0; bus.wdata_s_i = 8'h05;
        tick(); tick();
        n_vec++;
        if ({bus.stall_o, bus.done_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o,
             bus.mem_wdata_o, bus.rdata_v_o, bus.rdata_s_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got stall=%0b done=%0b en=%0b we=%0b addr=%h wd=%h rs=%h, required all 0",
                     bus.stall_o, bus.done_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o,
                     bus.mem_wdata_o, bus.rdata_s_o);
        end
        bus.req_i = 1'b1;
        #1;
        n_vec++;
        if (bus.stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_stall_req: got %0b, required 1", bus.stall_o);
        end
        // requests held during reset must not start anything (tick flags strobes)
        tick(); tick();
        n_vec++;
        if (bus.mem_en_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req_ignored: got en=%0b done=%0b, required 0 0", bus.mem_en_o, bus.done_o);
        end
        rst = 1'b0;
        $display("reset released with req_i high");
    endtask

    task automatic test_scalar_write();
        run_op(1'b0, 1'b1, 32'h10000, '0, 8'h05, 1'b0, 0, "scalar_write");
        n_vec++;
        if (mem_rd(32'h10000) !== 8'h05) begin
            n_err++;
            $display("FAIL scalar_write_mem: got %h, required 05", mem_rd(32'h10000));
        end
    endtask

    task automatic test_vector_read();
        for (int k = 0; k < I; k++) mem[32'h10000 + k] = L'(k);
        run_op(1'b1, 1'b0, 32'h10000, '0, '0, 1'b0, 0, "vector_read");
    endtask

    task automatic test_wrap();
        run_op(1'b1, 1'b1, 32'hFFFFFFFF, rand_vec(), '0, 1'b0, 0, "wrap_write");
    endtask

    task automatic test_busy();
        run_op(1'b1, 1'b1, 32'h50000, rand_vec(), '0, 1'b0, 4, "busy_write");
        tick(); tick(); tick();
        n_vec++;
        if (n_done != 1 || n_strobe != I) begin
            n_err++;
            $display("FAIL busy_counts: got done=%0d strobes=%0d, required 1 %0d", n_done, n_strobe, I);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [I*L-1:0] wv;
        strobe_t s;
        wv = rand_vec();
        n_strobe = 0;
        bus.req_i = 1'b1; bus.op_vector_i = 1'b1; bus.we_i = 1'b1;
        bus.addr_i = 32'h20000; bus.wdata_v_i = wv;
        for (int k = 0; k < I; k++) begin
            s.we = 1'b1; s.addr = 32'h20000 + A'(k); s.data = wv[k*L +: L];
            exp_q.push_back(s);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.req_i = 1'b0;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== 32'h20005) begin
            n_err++;
            $display("FAIL rst_mid_beat5: got en=%0b addr=%h, required 1 00020005", bus.mem_en_o, bus.mem_addr_o);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.stall_o, bus.done_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o,
             bus.mem_wdata_o, bus.rdata_v_o, bus.rdata_s_o} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got stall=%0b done=%0b en=%0b we=%0b addr=%h rs=%h, required all 0",
                     bus.stall_o, bus.done_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.rdata_s_o);
        end
        exp_q.delete();
        model_rv = '0; model_rs = '0;
        tick(); tick();
        rst = 1'b0;
        n_vec++;
        if (n_strobe != 5) begin
            n_err++;
            $display("FAIL rst_mid_strobes: got %0d, required 5", n_strobe);
        end
        for (int k = 0; k < I; k++) begin
            n_vec++;
            if (k < 5 ? (mem_rd(32'h20000 + k) !== wv[k*L +: L]) : mem.exists(32'h20000 + k)) begin
                n_err++;
                $display("FAIL rst_mid_mem[%0d]: got %h exists=%0b, required %s", k,
                         mem_rd(32'h20000 + k), mem.exists(32'h20000 + k), k < 5 ? "written" : "untouched");
            end
        end
        $display("reset mid-op: %0d beats written before abort", n_strobe);
        run_op(1'b0, 1'b0, 32'h20002, '0, '0, 1'b0, 0, "after_reset_read");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < I; k++) mem[32'h30000 + k] = 8'hAA;
        mem[32'h40000] = 8'h3C;
        run_op(1'b1, 1'b0, 32'h30000, '0, '0, 1'b1, 0, "b2b_vector_read");
        // req_i is still high; the scalar read must be accepted at the end of
        // this cycle, so its done_o lands exactly three cycles from here
        run_op(1'b0, 1'b0, 32'h40000, '0, '0, 1'b0, 0, "b2b_scalar_read");
        n_vec++;
        if (bus.rdata_v_o !== {I{8'hAA}} || bus.rdata_s_o !== 8'h3C) begin
            n_err++;
            $display("FAIL b2b_results: got v=%h s=%h, required all AA and 3C", bus.rdata_v_o, bus.rdata_s_o);
        end
    endtask

    initial begin
        model_rv = '0; model_rs = '0; rd_pend = 1'b0; rd_addr = '0;
        bus.mem_rdata_i = 8'hEE;
        test_reset();
        test_scalar_write();
        test_vector_read();
        test_wrap();
        test_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 SHALL have parameter I, default 20, number of vector lanes.
REQ-002 SHALL have parameter L, default 8, lane/memory word width in bits.
REQ-003 SHALL have parameter A, default 32, byte-address width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_i  input  1  access request from the MEM pipeline stage.
REQ-007 SHALL have port op_vector_i  input  1  1 = vector (I beats), 0 = scalar (1 beat).
REQ-008 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port addr_i  input  A  base byte address.
REQ-010 SHALL have port wdata_v_i  input  I*L  vector write data; lane k occupies bits [k*L+L-1:k*L].
REQ-011 SHALL have port wdata_s_i  input  L  scalar write data.
REQ-012 SHALL have port stall_o  output  1  holds pipeline registers (drives enable_i low) while high.
REQ-013 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-014 SHALL have port rdata_v_o  output  I*L  vector read result, same lane packing as wdata_v_i.
REQ-015 SHALL have port rdata_s_o  output  L  scalar read result.
REQ-016 SHALL have port mem_en_o  output  1  memory access strobe.
REQ-017 SHALL have port mem_we_o  output  1  memory write enable; valid only with mem_en_o.
REQ-018 SHALL have port mem_addr_o  output  A  memory byte address.
REQ-019 SHALL have port mem_wdata_o  output  L  memory write byte.
REQ-020 SHALL have port mem_rdata_i  input  L  memory read byte, valid exactly one cycle after a read strobe.

Function
REQ-021 SHALL implement FSM IDLE, ACCESS, DRAIN, DONE.
REQ-022 SHALL stay in IDLE until req_i=1 is sampled at a rising edge, then latch op_vector_i, we_i, addr_i, wdata_v_i and wdata_s_i, clear the beat counter and enter ACCESS.
REQ-023 SHALL ignore req_i in ACCESS, DRAIN and DONE; no queuing.
REQ-024 SHALL, in ACCESS, drive for beat k: mem_en_o=1, mem_we_o=latched we, mem_addr_o=(base+k) mod 2^A, and mem_wdata_o=lane k (vector) or the scalar byte.
REQ-025 SHALL issue beats k=0..N-1 on consecutive cycles, with N=I for vector and N=1 for scalar; no idle cycles between beats.
REQ-026 SHALL leave ACCESS after beat N-1, going to DRAIN for a read and to DONE for a write.
REQ-027 SHALL capture mem_rdata_i one cycle after each read beat k into rdata_v_o lane k (vector) or rdata_s_o (scalar); the last capture occurs in DRAIN.
REQ-028 SHALL go from DRAIN to DONE unconditionally after one cycle.
REQ-029 SHALL assert done_o only in DONE, then return to IDLE; a request is accepted again no earlier than the following edge.
REQ-030 SHALL drive stall_o combinationally: 1 when (IDLE and req_i) or in ACCESS or in DRAIN; 0 in DONE so the pipeline advances on the DONE edge.
REQ-031 SHALL make latency from the acceptance edge to done_o high: vector write I+1 cycles, vector read I+2, scalar write 2, scalar read 3.
REQ-032 SHALL never modify rdata_v_o on scalar ops or rdata_s_o on vector ops; results hold until overwritten or reset.
REQ-033 SHALL drive mem_en_o=0 and mem_we_o=0 outside ACCESS; mem_addr_o and mem_wdata_o are don't-care when mem_en_o=0 but SHALL not be X.
REQ-034 SHALL not depend on input changes after acceptance, because all operands are latched at acceptance.

Reset
REQ-035 SHALL, on rst=1 at any time, immediately force IDLE, clear the counter and latches, and drive stall_o=0 (unless req_i is high), done_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_v_o=0 and rdata_s_o=0.
REQ-036 SHALL abort an in-flight operation on reset with no further memory strobes; beats already written remain in memory.
REQ-037 SHALL ignore req_i while rst=1; the first acceptance occurs on the first rising edge after deassertion with req_i=1.

Verification
REQ-038 SHALL be tested with a scalar write: req at addr 0x10000, wdata_s=0x05 -> exactly one strobe with we=1, addr 0x10000, data 0x05; done_o 2 cycles after acceptance.
REQ-039 SHALL be tested with a vector read: memory byte 0x10000+k = k, k=0..19 -> 20 consecutive strobes at 0x10000..0x10013; rdata_v_o lane k = k; done_o at cycle 22; stall_o high for cycles 0..21.
REQ-040 SHALL be tested with address wrap: vector write at base 0xFFFFFFFF -> strobe addresses 0xFFFFFFFF, 0x0, 0x1, ..., 0x12.
REQ-041 SHALL be tested with a busy request: a second req_i pulse during ACCESS of a vector write -> no extra strobes, exactly one done_o.
REQ-042 SHALL be tested with reset mid-op: rst asserted during beat 5 of a vector write -> mem_en_o low in the same cycle, only bytes 0..4 written, all outputs zero, next request served normally.
REQ-043 SHALL be tested with back-to-back scalar reads with req_i held high: a vector read of all 0xAA then a scalar read of 0x3C -> rdata_v_o stays all 0xAA, rdata_s_o=0x3C, and the second acceptance occurs on the edge after done_o.
